// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data-memory responder: access types, FSM states and
// the alignment / legality helpers.
package cpu_pkg;

  localparam int DMEM_WAIT_STATES = 1;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5
  } load_type;

  typedef enum logic [1:0] {
    ST_SB = 2'd0,
    ST_SH = 2'd1,
    ST_SW = 2'd2
  } store_type;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state;

  function automatic logic is_misaligned(logic [1:0] addr_lo, logic we, logic [2:0] ld_type,
                                         logic [1:0] st_type);
    if (we) begin
      return ((st_type == ST_SH) && addr_lo[0]) || ((st_type == ST_SW) && (addr_lo != 2'd0));
    end
    return (((ld_type == LD_LH) || (ld_type == LD_LHU)) && addr_lo[0]) ||
           ((ld_type == LD_LW) && (addr_lo != 2'd0));
  endfunction

  // Encodings 3, 6 and 7 are unused by RV32I loads; store encoding 3 is unused.
  function automatic logic is_illegal_type(logic we, logic [2:0] ld_type, logic [1:0] st_type);
    if (we) begin
      return st_type == 2'd3;
    end
    return (ld_type == 3'd3) || (ld_type == 3'd6) || (ld_type == 3'd7);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit word RAM: store byte enables / lane-replicated write data,
// and load lane selection with sign or zero extension.
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  st_type,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    case (st_type)
      ST_SB: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      ST_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      ST_SW: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    rbyte = 8'h00;
    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (ld_type)
      LD_LB:   rdata_ext = {{24{rbyte[7]}}, rbyte};
      LD_LH:   rdata_ext = {{16{rhalf[15]}}, rhalf};
      LD_LW:   rdata_ext = rword;
      LD_LBU:  rdata_ext = {24'h0, rbyte};
      LD_LHU:  rdata_ext = {16'h0, rhalf};
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, programmable wait, byte-lane RAM access,
// registered valid/ready response out.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = DMEM_WAIT_STATES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [2:0]       req_ld_type,
  input  logic [1:0]       req_st_type,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  mem_state          state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [2:0]        ld_q;
  logic [1:0]        st_q;
  logic              rsp_valid_q;
  logic [WIDTH-1:0]  rsp_rdata_q;
  logic              rsp_err_q;

  logic [7:0]        ram [4][DEPTH];

  logic              accept, commit, ram_we;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [WIDTH-1:0]  cur_wdata;
  logic [2:0]        cur_ld;
  logic [1:0]        cur_st;
  logic [AW-1:0]     widx;
  logic              out_of_range, err;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;
  logic [31:0]       rdata_ext;

  assign accept = req_valid && (state_q == MEM_IDLE);

  // With zero wait states the accept edge is also the commit edge, so the live request is used.
  always_comb begin
    if (state_q == MEM_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_ld    = req_ld_type;
      cur_st    = req_st_type;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_ld    = ld_q;
      cur_st    = st_q;
    end
  end

  assign commit = (accept && (WAIT_STATES == 0)) || ((state_q == MEM_WAIT) && (cnt_q == 4'd0));

  assign widx         = cur_addr[AW+1:2];
  assign out_of_range = (cur_addr >> (AW + 2)) != 32'd0;
  assign err          = out_of_range || is_misaligned(cur_addr[1:0], cur_we, cur_ld, cur_st) ||
                        is_illegal_type(cur_we, cur_ld, cur_st);
  assign ram_we       = commit && cur_we && !err && rst_n;

  assign rword = {ram[3][widx], ram[2][widx], ram[1][widx], ram[0][widx]};

  mem_lane_align u_align (
    .addr_lo    (cur_addr[1:0]),
    .ld_type    (cur_ld),
    .st_type    (cur_st),
    .wdata      (cur_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          ram[i][widx] <= wdata_lane[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MEM_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = MEM_RESP;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = MEM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_RESP: begin
        if (rsp_ready) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= '0;
      ld_q        <= 3'd0;
      st_q        <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        ld_q    <= req_ld_type;
        st_q    <= req_st_type;
      end
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= (cur_we || err) ? '0 : rdata_ext;
        rsp_err_q   <= err;
      end else if ((state_q == MEM_RESP) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign req_ready = (state_q == MEM_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a 1-wait-state instance, plus latency,
// backpressure and mid-flight reset sequences; 0- and 3-wait-state instances for latency.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_ld_type = 3'd0;
  logic [1:0]  req_st_type = 2'd0;
  logic        rsp_ready = 1'b0;
  int          sel = 1;

  logic [2:0]  rv;
  logic        rdy_v   [3];
  logic        valid_v [3];
  logic [31:0] rdata_v [3];
  logic        err_v   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rv = {req_valid && (sel == 2), req_valid && (sel == 1), req_valid && (sel == 0)};

  dmem_responder #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy_v[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ld_type(req_ld_type),
    .req_st_type(req_st_type), .rsp_valid(valid_v[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rdata_v[0]), .rsp_err(err_v[0])
  );

  dmem_responder #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy_v[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ld_type(req_ld_type),
    .req_st_type(req_st_type), .rsp_valid(valid_v[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rdata_v[1]), .rsp_err(err_v[1])
  );

  dmem_responder #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_ready(rdy_v[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ld_type(req_ld_type),
    .req_st_type(req_st_type), .rsp_valid(valid_v[2]), .rsp_ready(rsp_ready),
    .rsp_rdata(rdata_v[2]), .rsp_err(err_v[2])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_we      = v.we;
    req_addr    = v.addr;
    req_wdata   = v.wdata;
    req_ld_type = v.ld;
    req_st_type = v.st;
  endtask

  // Accept edge, then count further edges until rsp_valid; handshake one cycle.
  task automatic txn(input int k, input vec_t v, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    sel = k;
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!valid_v[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!valid_v[k]) check("rsp_timeout", 32'(valid_v[k]), 32'd1);
    rd = rdata_v[k];
    er = err_v[k];
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] ld, input logic [1:0] st,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.ld = ld; v.st = st;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    vec_t        vecs [$];
    vec_t        v;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          waited;

    // ld: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; st: 0 SB, 1 SH, 2 SW
    vecs.push_back(mk(1, 32'h10,   32'hDEADBEEF, 0, 2, 32'h0,        0));
    vecs.push_back(mk(0, 32'h10,   32'h0,        2, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h20,   32'h11223344, 0, 2, 32'h0,        0));
    vecs.push_back(mk(1, 32'h21,   32'h123456AA, 0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h20,   32'h0,        2, 0, 32'h1122AA44, 0));
    vecs.push_back(mk(0, 32'h21,   32'h0,        0, 0, 32'hFFFFFFAA, 0));
    vecs.push_back(mk(0, 32'h21,   32'h0,        4, 0, 32'h000000AA, 0));
    vecs.push_back(mk(0, 32'h22,   32'h0,        5, 0, 32'h00001122, 0));
    vecs.push_back(mk(1, 32'h20,   32'hABCD8001, 0, 1, 32'h0,        0));
    vecs.push_back(mk(0, 32'h20,   32'h0,        1, 0, 32'hFFFF8001, 0));
    vecs.push_back(mk(0, 32'h22,   32'h0,        2, 0, 32'h0,        1));
    vecs.push_back(mk(1, 32'h13,   32'h0000BEEF, 0, 1, 32'h0,        1));
    vecs.push_back(mk(0, 32'h10,   32'h0,        2, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        2, 0, 32'h0,        1));
    vecs.push_back(mk(1, 32'h1000, 32'h0,        0, 2, 32'h0,        1));
    vecs.push_back(mk(0, 32'h10,   32'h0,        3, 0, 32'h0,        1));
    vecs.push_back(mk(1, 32'h14,   32'h55667788, 0, 2, 32'h0,        0));
    vecs.push_back(mk(1, 32'h14,   32'hFFFFFFFF, 0, 3, 32'h0,        1));
    vecs.push_back(mk(1, 32'h17,   32'h00000099, 0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'h14,   32'h0,        2, 0, 32'h99667788, 0));
    vecs.push_back(mk(0, 32'h17,   32'h0,        0, 0, 32'hFFFFFF99, 0));
    vecs.push_back(mk(0, 32'h16,   32'h0,        1, 0, 32'hFFFF9966, 0));
    vecs.push_back(mk(0, 32'h21,   32'h0,        1, 0, 32'h0,        1));
    vecs.push_back(mk(0, 32'h10,   32'h0,        6, 0, 32'h0,        1));

    // Reset state
    #12;
    for (int k = 0; k < 3; k++) begin
      check("reset_req_ready", 32'(rdy_v[k]), 32'd1);
      check("reset_rsp_valid", 32'(valid_v[k]), 32'd0);
      check("reset_rsp_rdata", rdata_v[k], 32'h0);
      check("reset_rsp_err", 32'(err_v[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      txn(1, vecs[i], rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
    end

    // Latency with 0 and 3 wait states
    for (int k = 0; k < 3; k += 2) begin
      txn(k, mk(1, 32'h10, 32'hCAFEF00D, 0, 2, 0, 0), rd, er, lat);
      check($sformatf("ws%0d_sw_latency", k), 32'(lat), (k == 0) ? 32'd0 : 32'd3);
      txn(k, mk(0, 32'h10, 32'h0, 2, 0, 0, 0), rd, er, lat);
      check($sformatf("ws%0d_lw_rdata", k), rd, 32'hCAFEF00D);
      check($sformatf("ws%0d_lw_latency", k), 32'(lat), (k == 0) ? 32'd0 : 32'd3);
    end

    // Backpressure, with a second request held by the CPU throughout
    @(negedge clk);
    sel = 1;
    drive(mk(0, 32'h10, 32'h0, 2, 0, 0, 0));
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(mk(0, 32'h20, 32'h0, 2, 0, 0, 0));
    waited = 0;
    while (!valid_v[1] && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", 32'(valid_v[1]), 32'd1);
      check("bp_rsp_rdata", rdata_v[1], 32'hDEADBEEF);
      check("bp_req_ready", 32'(rdy_v[1]), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_after_hs_valid", 32'(valid_v[1]), 32'd0);
    check("bp_after_hs_ready", 32'(rdy_v[1]), 32'd1);
    @(posedge clk);
    #1;
    check("bp_second_accepted", 32'(rdy_v[1]), 32'd0);
    req_valid = 1'b0;
    waited = 0;
    while (!valid_v[1] && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("bp_second_rdata", rdata_v[1], 32'h11228001);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Reset while a store waits: the store must not land
    txn(1, mk(1, 32'h30, 32'h0, 0, 2, 0, 0), rd, er, lat);
    @(negedge clk);
    sel = 1;
    drive(mk(1, 32'h30, 32'h12345678, 0, 2, 0, 0));
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_in_wait_ready", 32'(rdy_v[1]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid_async", 32'(valid_v[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", 32'(rdy_v[1]), 32'd1);
    check("rst_release_valid", 32'(valid_v[1]), 32'd0);
    txn(1, mk(0, 32'h30, 32'h0, 2, 0, 0, 0), rd, er, lat);
    check("rst_word30_rdata", rd, 32'h0);
    check("rst_word30_err", 32'(er), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
